// File: rtl/eamta_pkg.sv
// Shared definitions for the register file: FSM encoding and default sizes.
package eamta_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_WIDTH = 8;
  localparam int RF_DEPTH = 8;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range check, same-cycle forwarding and output register.
module rf_read_port
  import eamta_pkg::*;
#(
  parameter  int WIDTH  = RF_WIDTH,
  parameter  int DEPTH  = RF_DEPTH,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] mem [DEPTH],
  input  logic             wr_hit_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic             in_range;
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  assign in_range = {1'b0, rd_addr} < DEPTH_W;

  // An entry being cleared this cycle reads as zero regardless of BYPASS.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (!in_range) begin
        rd_data_d = '0;
      end else if (clr_en && (rd_addr == clr_addr)) begin
        rd_data_d = '0;
      end else if ((BYPASS != 0) && wr_hit_en && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/register_file.sv
// Flop-based register file with one write port, two read ports and a
// sequential clear that zeroes one entry per cycle.
module register_file
  import eamta_pkg::*;
#(
  parameter  int WIDTH  = RF_WIDTH,
  parameter  int DEPTH  = RF_DEPTH,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             clr,
  output logic             busy,
  output logic             wr_err
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  rf_state_e        state_d, state_q;
  logic [AW-1:0]    ptr_d, ptr_q;
  logic             wr_err_d, wr_err_q;
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_in_range;
  logic             wr_accept;
  logic             clr_en;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;

  // clr wins over a same-cycle write; every write seen during CLEAR is rejected.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_d     = mem_q;
    wr_err_d  = 1'b0;
    wr_accept = 1'b0;
    clr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d  = CLEAR;
          ptr_d    = '0;
          wr_err_d = wr_en;
        end else if (wr_en) begin
          if (wr_in_range) begin
            wr_accept      = 1'b1;
            mem_d[wr_addr] = wr_data;
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        clr_en       = 1'b1;
        mem_d[ptr_q] = '0;
        wr_err_d     = wr_en;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_err_q <= wr_err_d;
      mem_q    <= mem_d;
    end
  end

  assign busy   = (state_q == CLEAR);
  assign wr_err = wr_err_q;

  rf_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BYPASS(BYPASS)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .mem      (mem_q),
    .wr_hit_en(wr_accept),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_en   (clr_en),
    .clr_addr (ptr_q),
    .rd_data  (rd_data_a)
  );

  rf_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BYPASS(BYPASS)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .mem      (mem_q),
    .wr_hit_en(wr_accept),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_en   (clr_en),
    .clr_addr (ptr_q),
    .rd_data  (rd_data_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: instance 0 is the default build, instance 1
// has BYPASS=0 and instance 2 has DEPTH=6.
module tb_register_file;

  logic       clk;
  logic       rst;
  logic       wr_en     [3];
  logic [2:0] wr_addr   [3];
  logic [7:0] wr_data   [3];
  logic       rd_en_a   [3];
  logic [2:0] rd_addr_a [3];
  logic       rd_en_b   [3];
  logic [2:0] rd_addr_b [3];
  logic [7:0] rd_data_a [3];
  logic [7:0] rd_data_b [3];
  logic       clr       [3];
  logic       busy      [3];
  logic       wr_err    [3];

  int checks   = 0;
  int failures = 0;

  register_file #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_en_a(rd_en_a[0]), .rd_addr_a(rd_addr_a[0]),
    .rd_en_b(rd_en_b[0]), .rd_addr_b(rd_addr_b[0]),
    .rd_data_a(rd_data_a[0]), .rd_data_b(rd_data_b[0]),
    .clr(clr[0]), .busy(busy[0]), .wr_err(wr_err[0])
  );

  register_file #(.WIDTH(8), .DEPTH(8), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_en_a(rd_en_a[1]), .rd_addr_a(rd_addr_a[1]),
    .rd_en_b(rd_en_b[1]), .rd_addr_b(rd_addr_b[1]),
    .rd_data_a(rd_data_a[1]), .rd_data_b(rd_data_b[1]),
    .clr(clr[1]), .busy(busy[1]), .wr_err(wr_err[1])
  );

  register_file #(.WIDTH(8), .DEPTH(6), .BYPASS(1)) dut6 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
    .rd_en_a(rd_en_a[2]), .rd_addr_a(rd_addr_a[2]),
    .rd_en_b(rd_en_b[2]), .rd_addr_b(rd_addr_b[2]),
    .rd_data_a(rd_data_a[2]), .rd_data_b(rd_data_b[2]),
    .clr(clr[2]), .busy(busy[2]), .wr_err(wr_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives every input of one instance for the coming clock edge.
  task automatic applyStimulus(input int d,
                               input logic we, input logic [2:0] wa, input logic [7:0] wd,
                               input logic rae, input logic [2:0] ra,
                               input logic rbe, input logic [2:0] rb,
                               input logic c);
    wr_en[d]     = we;
    wr_addr[d]   = wa;
    wr_data[d]   = wd;
    rd_en_a[d]   = rae;
    rd_addr_a[d] = ra;
    rd_en_b[d]   = rbe;
    rd_addr_b[d] = rb;
    clr[d]       = c;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) applyStimulus(d, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("reset_rd_a", rd_data_a[0], 8'h00);
    checkOutput("reset_rd_b", rd_data_b[0], 8'h00);
    checkOutput("reset_busy", busy[0], 1'b0);
    checkOutput("reset_wr_err", wr_err[0], 1'b0);
    rst = 1'b1;

    // Basic write then read on port A; port B stays idle.
    applyStimulus(0, 1, 3'd3, 8'hA5, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 3'd3, 0, 0, 0);
    tick();
    checkOutput("read_a_3", rd_data_a[0], 8'hA5);
    checkOutput("idle_b_zero", rd_data_b[0], 8'h00);
    applyStimulus(0, 0, 0, 0, 0, 3'd0, 1, 3'd3, 0);
    tick();
    checkOutput("hold_a", rd_data_a[0], 8'hA5);
    checkOutput("read_b_3", rd_data_b[0], 8'hA5);

    // Same-cycle write and read, with and without forwarding.
    applyStimulus(0, 1, 3'd5, 8'h3C, 1, 3'd5, 0, 0, 0);
    applyStimulus(1, 1, 3'd5, 8'h11, 0, 0, 0, 0, 0);
    tick();
    checkOutput("bypass_a", rd_data_a[0], 8'h3C);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 3'd5, 8'h22, 1, 3'd5, 0, 0, 0);
    tick();
    checkOutput("nobypass_old", rd_data_a[1], 8'h11);
    applyStimulus(1, 0, 0, 0, 1, 3'd5, 1, 3'd5, 0);
    tick();
    checkOutput("nobypass_new_a", rd_data_a[1], 8'h22);
    checkOutput("nobypass_new_b", rd_data_b[1], 8'h22);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // DEPTH=6: out-of-range write and read.
    applyStimulus(2, 1, 3'd5, 8'h44, 0, 0, 0, 0, 0);
    tick();
    checkOutput("d6_inrange_err", wr_err[2], 1'b0);
    applyStimulus(2, 1, 3'd7, 8'hFF, 0, 0, 0, 0, 0);
    tick();
    checkOutput("d6_err_pulse", wr_err[2], 1'b1);
    applyStimulus(2, 0, 0, 0, 0, 0, 1, 3'd6, 0);
    tick();
    checkOutput("d6_err_clear", wr_err[2], 1'b0);
    checkOutput("d6_read_6", rd_data_b[2], 8'h00);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2, 0, 0, 0, 1, 3'(i), 0, 0, 0);
      tick();
      checkOutput($sformatf("d6_entry_%0d", i), rd_data_a[2], (i == 5) ? 8'h44 : 8'h00);
    end
    applyStimulus(2, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fill all entries, then clear with a rejected write and reads in flight.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 3'(i), 8'h10 + 8'(i), 0, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i), 0);
      tick();
      checkOutput($sformatf("fill_a_%0d", i), rd_data_a[0], 8'h10 + 8'(i));
      checkOutput($sformatf("fill_b_%0d", i), rd_data_b[0], 8'h17 - 8'(i));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("clr_busy_%0d", k), busy[0], 1'b1);
      applyStimulus(0, (k == 1), 3'd2, 8'hEE, (k == 3), 3'd3, (k == 3), 3'd6, (k == 5));
      tick();
      if (k == 1) checkOutput("clr_wr_err", wr_err[0], 1'b1);
      if (k == 2) checkOutput("clr_wr_err_once", wr_err[0], 1'b0);
      if (k == 3) begin
        checkOutput("clr_read_cur", rd_data_a[0], 8'h00);
        checkOutput("clr_read_old", rd_data_b[0], 8'h16);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("clr_done_busy", busy[0], 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 3'(i), 1, 3'(i), 0);
      tick();
      checkOutput($sformatf("post_clr_a_%0d", i), rd_data_a[0], 8'h00);
      checkOutput($sformatf("post_clr_b_%0d", i), rd_data_b[0], 8'h00);
    end

    // clr and a write in the same idle cycle: clear wins.
    applyStimulus(0, 1, 3'd1, 8'h77, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 3'd1, 8'h55, 0, 0, 0, 0, 1);
    tick();
    checkOutput("prio_busy", busy[0], 1'b1);
    checkOutput("prio_wr_err", wr_err[0], 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (7) tick();
    checkOutput("prio_busy_last", busy[0], 1'b1);
    tick();
    checkOutput("prio_busy_end", busy[0], 1'b0);
    applyStimulus(0, 0, 0, 0, 1, 3'd1, 0, 0, 0);
    tick();
    checkOutput("prio_mem1", rd_data_a[0], 8'h00);

    // Reset in the middle of a clear.
    applyStimulus(0, 1, 3'd0, 8'h99, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 3'd7, 8'h88, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 3'd7, 0, 0, 0);
    tick();
    checkOutput("midclr_read_7", rd_data_a[0], 8'h88);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_busy", busy[0], 1'b0);
    checkOutput("rst_rd_a", rd_data_a[0], 8'h00);
    checkOutput("rst_wr_err", wr_err[0], 1'b0);
    rst = 1'b1;
    applyStimulus(0, 1, 3'd4, 8'h5A, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rst_accept_err", wr_err[0], 1'b0);
    applyStimulus(0, 0, 0, 0, 1, 3'd7, 1, 3'd0, 0);
    tick();
    checkOutput("rst_mem7", rd_data_a[0], 8'h00);
    checkOutput("rst_mem0", rd_data_b[0], 8'h00);
    applyStimulus(0, 0, 0, 0, 1, 3'd4, 0, 0, 0);
    tick();
    checkOutput("rst_mem4", rd_data_a[0], 8'h5A);
    checkOutput("rst_idle_busy", busy[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
